// File: rtl/lab04_pkg.sv
// Shared definitions for the Lab04 arithmetic datapath.
// Holds the default operand width and the multiplier controller state type
// so the top level and any neighbouring blocks agree on both.
package lab04_pkg;

    // Default operand width used by the Lab04 top; the product is twice this wide.
    localparam int WIDTH_DEF = 4;

    // Controller states of the sequential multiply-accumulate unit.
    //   IDLE : waiting for a start request, operands not yet captured
    //   RUN  : consuming one multiplier bit per clock
    //   DONE : publishing the accumulated result, then returning to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add step of the multiplier.
// Given the running accumulator, the multiplicand, the current multiplier
// bit and its bit position, produce the accumulator value after that bit
// has been folded in. Purely combinational; the top level owns all state.
module mul_step #(
    parameter int WIDTH   = 4,
    parameter int SHIFT_W = 2
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    input  logic [SHIFT_W-1:0] shift,
    output logic [2*WIDTH-1:0] next_acc
);

    logic [2*WIDTH-1:0] mcand_ext;
    logic [2*WIDTH-1:0] partial;

    // Widen the multiplicand to the accumulator width before shifting so
    // that no high bits of the partial product are lost at the top positions.
    always_comb begin
        mcand_ext = {{WIDTH{1'b0}}, mcand};
        partial   = mcand_ext << shift;
    end

    // Add the partial product only when the current multiplier bit is set;
    // the sum cannot overflow because the final result fits in 2*WIDTH bits.
    always_comb begin
        next_acc = acc;
        if (mbit) begin
            next_acc = acc + partial;
        end
    end

endmodule

// File: rtl/mul_4b_seq.sv
// Sequential shift-add multiply-accumulate: product = multiplicand*multiplier + addend.
// Operands are captured when a start request is accepted in IDLE, then one
// multiplier bit is processed per clock. The result is published through a
// registered product with a one-cycle done pulse, and held until the next
// completion or a reset. Used in the Lab04 top to rebuild a dividend from the
// Lab03 divider's quotient, divisor and remainder.
import lab04_pkg::*;

module mul_4b_seq #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    // Counter wide enough to address every multiplier bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Bit index at which the RUN phase ends.
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Controller state.
    mul_state_t state;
    mul_state_t next_state;

    // Captured operands; these are the only copies the datapath reads after
    // the start cycle, so the input pins are free to change during RUN.
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // Running accumulator and the index of the multiplier bit being processed.
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;

    // Registered outputs.
    logic [2*WIDTH-1:0] product_q;
    logic               done_q;

    // Accumulator value after folding in the current multiplier bit.
    logic [2*WIDTH-1:0] step_acc;
    logic               cur_bit;

    // Select the multiplier bit addressed by the counter.
    always_comb begin
        cur_bit = mplier_q[count_q];
    end

    mul_step #(
        .WIDTH   (WIDTH),
        .SHIFT_W (CW)
    ) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .mbit     (cur_bit),
        .shift    (count_q),
        .next_acc (step_acc)
    );

    // State register; reset aborts any operation in flight and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is honoured only in IDLE, RUN lasts exactly
    // WIDTH cycles regardless of operand values, DONE lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (count_q == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on an accepted start, step the accumulator
    // in RUN, and publish the result when leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= multiplicand;
                        mplier_q <= multiplier;
                        acc_q    <= {{WIDTH{1'b0}}, addend};
                        count_q  <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= step_acc;
                    count_q <= count_q + CW'(1);
                end
                DONE: begin
                    product_q <= acc_q;
                end
                default: begin
                    count_q <= '0;
                end
            endcase
        end
    end

    // Done pulse is registered alongside the product so both change on the
    // same edge; it can only follow a DONE state, which only follows RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
        end
    end

    // Busy mirrors the RUN state; it is low in DONE and in the done-pulse
    // cycle, so busy and done are never high together.
    always_comb begin
        busy    = (state == RUN);
        product = product_q;
        done    = done_q;
    end

endmodule

// File: tb/tb_mul_4b_seq.sv
// Self-checking bench for mul_4b_seq.
// Expected products come from plain integer arithmetic a*b+c; timing
// expectations (busy length, done latency, one done per accepted start)
// come from the handshake rules of the block.
module tb_mul_4b_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   addend;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int checks;
    int errors;

    // Result the block should be holding right now.
    int held_product;

    mul_4b_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and on mismatch count and report the failure.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Issue one start pulse with the given operands and follow the operation
    // to completion. With noisy=1 the bench keeps start high and scrambles
    // the operand inputs throughout RUN and DONE, which must not matter.
    task automatic applyStimulus(input int a, input int b, input int c, input bit noisy, input string tag);
        int cyc;
        int busy_cycles;
        int expected;
        expected = a * b + c;
        @(negedge clk);
        multiplicand = W'(a);
        multiplier   = W'(b);
        addend       = W'(c);
        start        = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cyc         = 0;
        busy_cycles = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cycles++;
            checkOutput({tag, " held"}, int'(product), held_product);
            if (noisy) begin
                start        = 1'b1;
                multiplicand = W'($urandom_range(0, 15));
                multiplier   = W'($urandom_range(0, 15));
                addend       = W'($urandom_range(0, 15));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput({tag, " done"}, int'(done), 1);
        checkOutput({tag, " latency"}, cyc, W + 1);
        checkOutput({tag, " busy_cycles"}, busy_cycles, W);
        checkOutput({tag, " busy_at_done"}, int'(busy), 0);
        checkOutput({tag, " product"}, int'(product), expected);
        held_product = expected;
        @(negedge clk);
        checkOutput({tag, " done_pulse"}, int'(done), 0);
        checkOutput({tag, " product_hold"}, int'(product), held_product);
    endtask

    initial begin
        int dones;
        checks       = 0;
        errors       = 0;
        held_product = 0;
        rst          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;

        // 1) reset pulse, no start: outputs stay quiet for 20 cycles
        #2 rst = 1'b1;
        #10 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle product", int'(product), 0);
            checkOutput("idle busy", int'(busy), 0);
            checkOutput("idle done", int'(done), 0);
        end

        // 2) basic operation
        applyStimulus(3, 5, 1, 1'b0, "3*5+1");

        // 3) extreme operands
        applyStimulus(15, 15, 15, 1'b0, "15*15+15");
        applyStimulus(0, 0, 0, 1'b0, "0*0+0");

        // 4) divider round trip: 14/4 -> q=3, r=2
        applyStimulus(3, 4, 2, 1'b0, "roundtrip");

        // 5) start held and operands scrambled during RUN and DONE
        applyStimulus(9, 11, 6, 1'b1, "noisy");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
            checkOutput("noisy after busy", int'(busy), 0);
        end
        checkOutput("noisy extra dones", dones, 0);
        checkOutput("noisy after product", int'(product), held_product);
        applyStimulus(5, 6, 7, 1'b0, "after noisy");

        // 6) asynchronous reset in the second RUN cycle
        @(negedge clk);
        multiplicand = 4'd12;
        multiplier   = 4'd13;
        addend       = 4'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst product", int'(product), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        held_product = 0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checkOutput("rst no activity", dones, 0);
        checkOutput("rst product stays", int'(product), 0);
        applyStimulus(7, 2, 0, 1'b0, "7*2+0");

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always ends even if a wait misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
